// File: rtl/wm_panel_input.sv
// Front-panel conditioner: synchronises and debounces the panel keys and switches, then turns
// key presses into registered run/pause/mode commands for the washing-machine controller.
module wm_panel_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned NUM_MODES       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_pause_n,
  input  logic       key_mode_n,
  input  logic       sw_cover,
  input  logic       sw_water,
  output logic       start,
  output logic       pause,
  output logic [1:0] mode,
  output logic       cover_closed,
  output logic       water_connected,
  output logic [1:0] run_state
);

  localparam int unsigned NumIn = 5;
  // Bit order: {water, cover, mode key, pause key, start key}; keys idle high, switches low.
  localparam logic [NumIn-1:0] IdleLvl = 5'b00111;
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       ModeMax = 2'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    StStopped = 2'd0,
    StRunning = 2'd1,
    StPaused  = 2'd2
  } run_state_e;

  logic [NumIn-1:0] raw;
  logic [NumIn-1:0] sync1_q, sync2_q, filt_q, filt_prev_q;
  logic [CNT_W-1:0] cnt_q [NumIn];

  run_state_e state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       start_q, pause_q;
  logic       press_start, press_pause, press_mode, ok;

  assign raw = {sw_water, sw_cover, key_mode_n, key_pause_n, key_start_n};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= IdleLvl;
      sync2_q     <= IdleLvl;
      filt_q      <= IdleLvl;
      filt_prev_q <= IdleLvl;
      for (int i = 0; i < NumIn; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      filt_prev_q <= filt_q;
      for (int i = 0; i < NumIn; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Falling edge of a filtered key is a press; releases and holds produce nothing.
  assign press_start = filt_prev_q[0] & ~filt_q[0];
  assign press_pause = filt_prev_q[1] & ~filt_q[1];
  assign press_mode  = filt_prev_q[2] & ~filt_q[2];
  assign ok          = filt_q[3] & filt_q[4];

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      StStopped: begin
        // Only the highest-priority pulse of the cycle is acted on.
        if (press_start) begin
          if (ok) state_d = StRunning;
        end else if (!press_pause && press_mode) begin
          mode_d = (mode_q == ModeMax) ? 2'd0 : mode_q + 2'd1;
        end
      end
      StRunning: begin
        if (!ok)              state_d = StPaused;
        else if (press_start) state_d = StStopped;
        else if (press_pause) state_d = StPaused;
      end
      StPaused: begin
        if (press_start)              state_d = StStopped;
        else if (press_pause && ok)   state_d = StRunning;
      end
      default: state_d = StStopped;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StStopped;
      mode_q  <= 2'd0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      start_q <= (state_d == StRunning);
      pause_q <= (state_d == StPaused);
    end
  end

  assign start           = start_q;
  assign pause           = pause_q;
  assign mode            = mode_q;
  assign run_state       = state_q;
  assign cover_closed    = filt_q[3];
  assign water_connected = filt_q[4];

endmodule

// File: tb/tb_wm_panel_input.sv
// Bench for wm_panel_input: directed panel scenarios plus random key/switch activity, all
// compared every cycle against a behavioural model of the panel rules.
module tb_wm_panel_input;

  localparam int Deb      = 4;
  localparam int NumModes = 3;

  logic clk = 1'b0;
  logic reset;
  logic key_start_n, key_pause_n, key_mode_n, sw_cover, sw_water;
  logic start, pause, cover_closed, water_connected;
  logic [1:0] mode, run_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wm_panel_input #(
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W          (20),
    .NUM_MODES      (NumModes)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_start_n    (key_start_n),
    .key_pause_n    (key_pause_n),
    .key_mode_n     (key_mode_n),
    .sw_cover       (sw_cover),
    .sw_water       (sw_water),
    .start          (start),
    .pause          (pause),
    .mode           (mode),
    .cover_closed   (cover_closed),
    .water_connected(water_connected),
    .run_state      (run_state)
  );

  // Model: 0 stopped, 1 running, 2 paused. Inputs reach the filter two edges late and the
  // filtered level flips once the delayed level has disagreed for Deb consecutive cycles.
  int       m_state, m_mode;
  bit [4:0] m_filt, m_prev, m_d1, m_d2;
  int       m_run [5];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_mode  = 0;
    m_filt  = 5'b00111;
    m_prev  = 5'b00111;
    m_d1    = 5'b00111;
    m_d2    = 5'b00111;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
  endtask

  task automatic model_step(input bit [4:0] raw);
    bit ps, pp, pm, ok;
    int ns;
    ps = m_prev[0] && !m_filt[0];
    pp = m_prev[1] && !m_filt[1];
    pm = m_prev[2] && !m_filt[2];
    ok = m_filt[3] && m_filt[4];
    ns = m_state;
    if (m_state == 0) begin
      if (ps) begin
        if (ok) ns = 1;
      end else if (!pp && pm) begin
        m_mode = (m_mode + 1) % NumModes;
      end
    end else if (m_state == 1) begin
      if (!ok)     ns = 2;
      else if (ps) ns = 0;
      else if (pp) ns = 2;
    end else begin
      if (ps)            ns = 0;
      else if (pp && ok) ns = 1;
    end
    m_state = ns;
    m_prev  = m_filt;
    for (int i = 0; i < 5; i++) begin
      if (m_d2[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == Deb) begin
          m_filt[i] = m_d2[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = raw;
  endtask

  task automatic compare_all();
    chk("start", 8'(start), 8'(m_state == 1));
    chk("pause", 8'(pause), 8'(m_state == 2));
    chk("mode", 8'(mode), 8'(m_mode));
    chk("run_state", 8'(run_state), 8'(m_state));
    chk("cover_closed", 8'(cover_closed), 8'(m_filt[3]));
    chk("water_connected", 8'(water_connected), 8'(m_filt[4]));
  endtask

  task automatic tick();
    bit [4:0] raw;
    bit       r;
    raw = {sw_water, sw_cover, key_mode_n, key_pause_n, key_start_n};
    r   = reset;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(raw);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       key_start_n = v;
      1:       key_pause_n = v;
      default: key_mode_n  = v;
    endcase
  endtask

  task automatic press(input int k, input int hold, input int gap);
    set_key(k, 1'b0);
    ticks(hold);
    set_key(k, 1'b1);
    ticks(gap);
  endtask

  initial begin
    reset       = 1'b1;
    key_start_n = 1'b1;
    key_pause_n = 1'b1;
    key_mode_n  = 1'b1;
    sw_cover    = 1'b0;
    sw_water    = 1'b0;
    model_reset();
    #1;
    ticks(2);
    reset = 1'b0;
    chk("rst_run_state", 8'(run_state), 8'd0);
    chk("rst_mode", 8'(mode), 8'd0);
    chk("rst_start_pause", 8'({start, pause}), 8'd0);
    ticks(3);

    // Long hold gives a single step, then two more presses wrap the mode.
    press(2, 20, 10);
    chk("mode_hold_one_step", 8'(mode), 8'd1);
    press(2, 8, 10);
    chk("mode_step2", 8'(mode), 8'd2);
    press(2, 8, 10);
    chk("mode_wrap", 8'(mode), 8'd0);

    // Bouncing start key never settles long enough to register.
    for (int i = 0; i < 8; i++) begin
      key_start_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      ticks(2);
    end
    key_start_n = 1'b1;
    ticks(12);
    chk("bounce_stays_stopped", 8'(run_state), 8'd0);

    // Start latency from the raw edge, then pause and resume.
    sw_cover = 1'b1;
    sw_water = 1'b1;
    ticks(10);
    chk("interlock_ok", 8'({cover_closed, water_connected}), 8'b11);
    key_start_n = 1'b0;
    ticks(Deb + 2);
    chk("start_not_early", 8'(start), 8'd0);
    tick();
    chk("start_latency", 8'(start), 8'd1);
    ticks(3);
    key_start_n = 1'b1;
    ticks(10);
    press(1, 8, 10);
    chk("paused_pause", 8'(pause), 8'd1);
    chk("paused_start", 8'(start), 8'd0);
    press(1, 8, 10);
    chk("resumed", 8'(run_state), 8'd1);

    // Water loss forces a pause that cannot be resumed until water returns.
    sw_water = 1'b0;
    ticks(10);
    chk("fault_pause", 8'(run_state), 8'd2);
    press(1, 8, 10);
    chk("pause_blocked_no_water", 8'(run_state), 8'd2);
    sw_water = 1'b1;
    ticks(10);
    press(1, 8, 10);
    chk("resume_after_water", 8'(run_state), 8'd1);

    // Stop, set mode 1, then start is refused with the cover open.
    press(0, 8, 10);
    chk("stopped", 8'(run_state), 8'd0);
    press(2, 8, 10);
    chk("mode_one", 8'(mode), 8'd1);
    sw_cover = 1'b0;
    ticks(10);
    press(0, 8, 10);
    chk("start_refused_cover", 8'(run_state), 8'd0);
    sw_cover = 1'b1;
    ticks(10);
    press(0, 8, 10);
    chk("running_again", 8'(run_state), 8'd1);
    // Simultaneous start and mode while running: start wins, mode is untouched.
    key_start_n = 1'b0;
    key_mode_n  = 1'b0;
    ticks(10);
    key_start_n = 1'b1;
    key_mode_n  = 1'b1;
    ticks(10);
    chk("start_mode_same_cycle_state", 8'(run_state), 8'd0);
    chk("start_mode_same_cycle_mode", 8'(mode), 8'd1);

    // Reset while running with mode 2 restores everything in one edge.
    press(2, 8, 10);
    press(0, 8, 10);
    chk("pre_reset_running", 8'({mode, run_state}), 8'b1001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_outputs", 8'({start, pause, mode, run_state}), 8'd0);
    ticks(4);

    // Random single-key presses, switch changes, idles and rare resets.
    for (int n = 0; n < 250; n++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act <= 5) begin
        press($urandom_range(0, 2), $urandom_range(1, 12), $urandom_range(1, 12));
      end else if (act == 6) begin
        sw_cover = 1'($urandom_range(0, 1));
        ticks($urandom_range(1, 10));
      end else if (act == 7) begin
        sw_water = 1'($urandom_range(0, 1));
        ticks($urandom_range(1, 10));
      end else if (act == 8) begin
        ticks($urandom_range(1, 8));
      end else if ($urandom_range(0, 4) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ticks(2);
      end else begin
        sw_cover = 1'b1;
        sw_water = 1'b1;
        ticks(8);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
